// File: rtl/pipe_pkg.sv
// Shared helpers for circular buffers: pointer wrap-increment for arbitrary
// (non-power-of-2) depths.
package pipe_pkg;

  function automatic logic [31:0] wrap_inc(input logic [31:0] ptr, input logic [31:0] depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/pipe_buf.sv
// Elastic pipeline buffer: DEPTH-entry circular buffer between two valid/ready
// stages, with selectable back-pressure mode, synchronous flush and occupancy.
module pipe_buf
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH      = 16,
  parameter int DEPTH           = 2,
  parameter int FULL_THROUGHPUT = 1,
  parameter int AFULL_THRESH    = DEPTH - 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         valid_in,
  output logic                         ready_out,
  input  logic [DATA_WIDTH-1:0]        data_in,
  output logic                         valid_out,
  input  logic                         ready_in,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         almost_full
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DEPTH < 1) begin : g_bad_depth
    $error("pipe_buf: DEPTH must be >= 1");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
    $error("pipe_buf: AFULL_THRESH must be in 1..DEPTH");
  end

  // Handshake: a transfer happens on a rising edge when valid and ready are
  // both high; push = valid_in & ready_out, pop = valid_out & ready_in.
  // valid_out is a pure decode of registered state, never of ready_in.

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  full, push, pop;

  assign full        = (count_q == CW'(DEPTH));
  assign valid_out   = (count_q != '0);
  assign almost_full = (count_q >= CW'(AFULL_THRESH));
  assign count       = count_q;
  assign data_out    = mem_q[head_q];

  if (FULL_THROUGHPUT != 0) begin : g_ft
    assign ready_out = ~flush & (~full | ready_in);
  end else begin : g_ht
    assign ready_out = ~flush & ~full;
  end

  assign push = valid_in & ready_out;
  assign pop  = valid_out & ready_in;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      // Any pop offered in a flush cycle is discarded along with the contents.
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = PW'(wrap_inc(32'(tail_q), 32'(DEPTH)));
      if (pop)  head_d = PW'(wrap_inc(32'(head_q), 32'(DEPTH)));
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage has no reset and is written only on push.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= data_in;
  end

endmodule
